// File: rtl/fp_add_pkg.sv
// Shared definitions for the sequential single-precision adder.
// Contents: the controller state enum, IEEE-754 format constants and the
// result flag bit positions. There are no ports.
package fp_add_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_DONE
    } state_t;

    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam int          FRAC_W    = 23;
    localparam int          MANT_W    = 24;

    // Exponent differences above this shift the smaller mantissa out entirely.
    localparam logic [7:0]  ALIGN_MAX = 8'd24;

    localparam int FLAG_W         = 3;
    localparam int FLAG_INVALID   = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    function automatic logic [FLAG_W-1:0] flag_bit(input int idx);
        logic [FLAG_W-1:0] f;
        f      = '0;
        f[idx] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/fp_add_seq_if.sv
// Operand/result handshake bundle for fp_add_seq.
// Signals:
//   in_valid/in_ready/in_a/in_b        operand pair handshake
//   out_valid/out_ready/out_result     result handshake
//   out_flags                          {invalid, overflow, underflow}
//   busy                               sequencer is working on an operation
// Modports: slave = adder side, master = operand source / result consumer.
interface fp_add_seq_if;
    import fp_add_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_a;
    logic [31:0]       in_b;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [FLAG_W-1:0] out_flags;
    logic              busy;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_flags, busy
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_flags, busy
    );

endinterface

// File: rtl/fp_add_datapath.sv
// Shared datapath of the sequential adder: operand registers, magnitude swap,
// exponent subtractor, 1-bit shifters, 25-bit add/subtract and result register.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   load_en                 capture op_a/op_b
//   prep_en                 unpack/swap, load working registers, resolve specials
//   align_en                one bit-serial alignment step
//   add_en                  mantissa add or subtract
//   norm_en                 one normalisation action
//   special                 captured pair is NaN/inf (result loaded during PREP)
//   align_skip              exponent difference needs no alignment cycles
//   align_last              current alignment step is the final one
//   norm_fin                current normalisation action completes the result
//   result, flags           registered result word and flags
module fp_add_datapath
    import fp_add_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              prep_en,
    input  logic              align_en,
    input  logic              add_en,
    input  logic              norm_en,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    output logic              special,
    output logic              align_skip,
    output logic              align_last,
    output logic              norm_fin,
    output logic [31:0]       result,
    output logic [FLAG_W-1:0] flags
);

    logic [31:0]       a_q, b_q;
    logic [31:0]       x, y;
    logic [7:0]        ex, ey, d_pre;
    logic [MANT_W-1:0] mx, my;
    logic              x_nan, y_nan, x_inf, y_inf, invalid, negz;

    logic              sgn_q, sub_q, negz_q;
    logic [7:0]        exp_q, d_q;
    logic [MANT_W-1:0] ma_q, mb_q;
    logic [MANT_W:0]   sum_q;
    logic              sum_zero;
    logic [31:0]       result_q;
    logic [FLAG_W-1:0] flags_q;

    // x always carries the larger {exp, frac}; ties keep operand A.
    always_comb begin
        if (a_q[30:0] >= b_q[30:0]) begin
            x = a_q;
            y = b_q;
        end else begin
            x = b_q;
            y = a_q;
        end
    end

    assign ex = x[30:FRAC_W];
    assign ey = y[30:FRAC_W];
    // Zero exponent means zero: denormal fractions are flushed.
    assign mx = (ex != 8'd0) ? {1'b1, x[FRAC_W-1:0]} : '0;
    assign my = (ey != 8'd0) ? {1'b1, y[FRAC_W-1:0]} : '0;

    assign d_pre = ex + (~ey + 8'd1);

    assign x_nan   = (ex == EXP_MAX) && (x[FRAC_W-1:0] != '0);
    assign y_nan   = (ey == EXP_MAX) && (y[FRAC_W-1:0] != '0);
    assign x_inf   = (ex == EXP_MAX) && (x[FRAC_W-1:0] == '0);
    assign y_inf   = (ey == EXP_MAX) && (y[FRAC_W-1:0] == '0);
    assign invalid = x_nan | y_nan | (x_inf & y_inf & (x[31] ^ y[31]));
    assign special = x_nan | y_nan | x_inf | y_inf;

    assign negz = a_q[31] & b_q[31] & (a_q[30:FRAC_W] == 8'd0) & (b_q[30:FRAC_W] == 8'd0);

    assign align_skip = (d_pre == 8'd0) || (d_pre > ALIGN_MAX);
    assign align_last = (d_q == 8'd1);

    assign sum_zero = (sum_q == '0);
    // Every action except a plain left shift finishes; a left shift finishes
    // too when it drives the exponent to zero.
    assign norm_fin = sum_q[MANT_W] | sum_zero | sum_q[MANT_W-1] | (exp_q == 8'd1);

    assign result = result_q;
    assign flags  = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            sub_q    <= 1'b0;
            negz_q   <= 1'b0;
            exp_q    <= '0;
            d_q      <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            sum_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            if (load_en) begin
                a_q <= op_a;
                b_q <= op_b;
            end

            if (prep_en) begin
                sgn_q  <= x[31];
                sub_q  <= x[31] ^ y[31];
                negz_q <= negz;
                exp_q  <= ex;
                d_q    <= d_pre;
                ma_q   <= mx;
                mb_q   <= (d_pre > ALIGN_MAX) ? '0 : my;
                if (special) begin
                    result_q <= invalid ? QNAN : x;
                    flags_q  <= invalid ? flag_bit(FLAG_INVALID) : '0;
                end
            end

            if (align_en) begin
                mb_q <= mb_q >> 1;
                d_q  <= d_q - 8'd1;
            end

            if (add_en) begin
                if (sub_q)
                    sum_q <= {1'b0, ma_q} + (~{1'b0, mb_q} + 25'd1);
                else
                    sum_q <= {1'b0, ma_q} + {1'b0, mb_q};
            end

            if (norm_en) begin
                if (sum_q[MANT_W]) begin
                    if (exp_q == EXP_MAX - 8'd1) begin
                        result_q <= {sgn_q, EXP_MAX, {FRAC_W{1'b0}}};
                        flags_q  <= flag_bit(FLAG_OVERFLOW);
                    end else begin
                        result_q <= {sgn_q, exp_q + 8'd1, sum_q[FRAC_W:1]};
                        flags_q  <= '0;
                    end
                end else if (sum_zero) begin
                    result_q <= {negz_q, 31'd0};
                    flags_q  <= '0;
                end else if (sum_q[MANT_W-1]) begin
                    result_q <= {sgn_q, exp_q, sum_q[FRAC_W-1:0]};
                    flags_q  <= '0;
                end else begin
                    sum_q <= sum_q << 1;
                    exp_q <= exp_q - 8'd1;
                    if (exp_q == 8'd1) begin
                        result_q <= {sgn_q, 31'd0};
                        flags_q  <= flag_bit(FLAG_UNDERFLOW);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder sequencer.
// Accepts an operand pair over in_valid/in_ready, walks the shared datapath
// through prepare, bit-serial align, add and bit-serial normalise, and holds
// the result on out_valid/out_ready until taken.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          fp_add_seq_if slave: both handshakes, result, flags, busy
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for an operand pair, in_ready high
// PREP   | unpack, swap, exponent difference, NaN/inf resolution
// ALIGN  | shift smaller mantissa right one bit per cycle
// ADD    | 25-bit add or subtract of the aligned mantissas
// NORM   | one normalisation action per cycle
// DONE   | result presented until out_ready
module fp_add_seq
    import fp_add_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    fp_add_seq_if.slave bus
);

    state_t state, state_nx;

    logic load_en, prep_en, align_en, add_en, norm_en;
    logic special, align_skip, align_last, norm_fin;

    fp_add_datapath u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .prep_en    (prep_en),
        .align_en   (align_en),
        .add_en     (add_en),
        .norm_en    (norm_en),
        .op_a       (bus.in_a),
        .op_b       (bus.in_b),
        .special    (special),
        .align_skip (align_skip),
        .align_last (align_last),
        .norm_fin   (norm_fin),
        .result     (bus.out_result),
        .flags      (bus.out_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load_en  = 1'b0;
        prep_en  = 1'b0;
        align_en = 1'b0;
        add_en   = 1'b0;
        norm_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    load_en  = 1'b1;
                    state_nx = ST_PREP;
                end
            end
            ST_PREP: begin
                prep_en = 1'b1;
                if (special)
                    state_nx = ST_DONE;
                else if (align_skip)
                    state_nx = ST_ADD;
                else
                    state_nx = ST_ALIGN;
            end
            ST_ALIGN: begin
                align_en = 1'b1;
                if (align_last)
                    state_nx = ST_ADD;
            end
            ST_ADD: begin
                add_en   = 1'b1;
                state_nx = ST_NORM;
            end
            ST_NORM: begin
                norm_en = 1'b1;
                if (norm_fin)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Handshake outputs decode the state register only.
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed cases from the adder's
// behaviour list plus randomised operand pairs scored against a
// behavioural model (result, flags and latency).
module tb_fp_add_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_add_seq_if bus_i ();

    fp_add_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural reference: exact integer arithmetic on the unpacked
    // operands, truncating alignment, leading-one search for normalisation.
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic [2:0] f, output int lat);
        int ea, eb, ex, ey, d, nalign, shift, p;
        logic [31:0] x, y;
        logic [7:0] e8;
        longint mx, my, s;
        bit nan_a, nan_b, inf_a, inf_b, negz;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 23'd0);
        nan_b = (eb == 255) && (b[22:0] != 23'd0);
        inf_a = (ea == 255) && (a[22:0] == 23'd0);
        inf_b = (eb == 255) && (b[22:0] == 23'd0);
        f = 3'b000;
        if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) begin
            r = 32'h7FC00000; f = 3'b100; lat = 1; return;
        end
        if (inf_a) begin r = a; lat = 1; return; end
        if (inf_b) begin r = b; lat = 1; return; end
        if (b[30:0] > a[30:0]) begin x = b; y = a; end
        else begin x = a; y = b; end
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = (ex != 0) ? ((longint'(1) << 23) + longint'(x[22:0])) : 0;
        my = (ey != 0) ? ((longint'(1) << 23) + longint'(y[22:0])) : 0;
        d = ex - ey;
        nalign = (d >= 1 && d <= 24) ? d : 0;
        my = (d > 24) ? 0 : (my >> d);
        s = (x[31] == y[31]) ? (mx + my) : (mx - my);
        negz = a[31] && b[31] && (ea == 0) && (eb == 0);
        if (s == 0) begin
            r = {negz, 31'd0}; lat = 3 + nalign; return;
        end
        if (s >= (longint'(1) << 24)) begin
            if (ex + 1 == 255) begin
                r = {x[31], 8'hFF, 23'd0}; f = 3'b010;
            end else begin
                e8 = 8'(ex + 1);
                r = {x[31], e8, 23'((s >> 1) & 64'h7FFFFF)};
            end
            lat = 3 + nalign; return;
        end
        p = 23;
        while (((s >> p) & 1) == 0) p--;
        shift = 23 - p;
        if (shift > 0 && ex <= shift) begin
            r = {x[31], 31'd0}; f = 3'b001; lat = 2 + nalign + ex;
        end else begin
            e8 = 8'(ex - shift);
            r = {x[31], e8, 23'((s << shift) & 64'h7FFFFF)};
            lat = 2 + nalign + shift + 1;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [2:0] ef, input int el, input int hold);
        int lat;
        check_val($sformatf("%s ready", tag), 32'(bus_i.in_ready), 32'd1);
        bus_i.in_a = a;
        bus_i.in_b = b;
        bus_i.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_i.in_valid = 1'b0;
        lat = 0;
        while (!bus_i.out_valid && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val($sformatf("%s valid", tag), 32'(bus_i.out_valid), 32'd1);
        check_val($sformatf("%s result", tag), bus_i.out_result, er);
        check_val($sformatf("%s flags", tag), 32'(bus_i.out_flags), 32'(ef));
        check_val($sformatf("%s latency", tag), 32'(lat), 32'(el));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val($sformatf("%s hold valid", tag), 32'(bus_i.out_valid), 32'd1);
            check_val($sformatf("%s hold result", tag), bus_i.out_result, er);
            check_val($sformatf("%s hold in_ready", tag), 32'(bus_i.in_ready), 32'd0);
        end
        bus_i.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_i.out_ready = 1'b0;
        check_val($sformatf("%s idle ready", tag), 32'(bus_i.in_ready), 32'd1);
        check_val($sformatf("%s idle busy", tag), 32'(bus_i.busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, rnd, er;
        logic [2:0]  ef;
        int          el, e;
        rst_n = 1'b0;
        bus_i.in_valid = 1'b0;
        bus_i.in_a = '0;
        bus_i.in_b = '0;
        bus_i.out_ready = 1'b0;
        #12;
        check_val("rst in_ready", 32'(bus_i.in_ready), 32'd1);
        check_val("rst out_valid", 32'(bus_i.out_valid), 32'd0);
        check_val("rst busy", 32'(bus_i.busy), 32'd0);
        check_val("rst result", bus_i.out_result, 32'd0);
        check_val("rst flags", 32'(bus_i.out_flags), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 3, 0);
        run_op("cancel", 32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000, 3, 0);
        run_op("align3", 32'h3F800000, 32'h3E000000, 32'h3F900000, 3'b000, 6, 0);

        // Reset during ALIGN of 1.0 + 0.125; result register still holds 0x3F900000.
        bus_i.in_a = 32'h3F800000;
        bus_i.in_b = 32'h3E000000;
        bus_i.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_i.in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("pre_rst busy", 32'(bus_i.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("midrst in_ready", 32'(bus_i.in_ready), 32'd1);
        check_val("midrst out_valid", 32'(bus_i.out_valid), 32'd0);
        check_val("midrst busy", 32'(bus_i.busy), 32'd0);
        check_val("midrst result", bus_i.out_result, 32'd0);
        check_val("midrst flags", 32'(bus_i.out_flags), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 3, 0);

        run_op("inf_clash", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100, 1, 0);
        run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010, 3, 0);
        run_op("backpressure", 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 3, 5);
        run_op("underflow", 32'h00800001, 32'h80800000, 32'h00000000, 3'b001, 3, 0);
        run_op("neg_zeros", 32'h80000000, 32'h80000000, 32'h80000000, 3'b000, 3, 0);
        run_op("inf_pass", 32'h3F800000, 32'hFF800000, 32'hFF800000, 3'b000, 1, 0);
        run_op("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 1, 0);

        for (int k = 0; k < 300; k++) begin
            a = $urandom;
            rnd = $urandom;
            e = int'(a[30:23]) + int'($urandom_range(0, 60)) - 30;
            if (e < 0) e = 0;
            if (e > 255) e = 255;
            case ($urandom_range(0, 9))
                0:       b = {rnd[31], 8'hFF, (rnd[23] ? 23'd0 : rnd[22:0])};
                1:       b = {rnd[31], 8'h00, rnd[22:0]};
                2, 3:    b = {~a[31], a[30:8], rnd[7:0]};
                default: b = {rnd[31], 8'(e), rnd[22:0]};
            endcase
            if ($urandom_range(0, 1) == 1) begin
                rnd = a;
                a = b;
                b = rnd;
            end
            ref_model(a, b, er, ef, el);
            run_op($sformatf("rnd%0d %h+%h", k, a, b), a, b, er, ef, el, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
